rr_req_agent: RTL and testbench

//  Requester side of the round-robin arbiter interface. Holds one small FIFO per master.

---
 rtl/rr_req_agent.sv | 166 ++++++++++++++++
 tb/tb_rr_req_agent.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_agent.sv
// rr_req_agent: per-master FIFOs raise requests to a round-robin arbiter; the granted head
// moves into one registered valid/ready slot. Optional starvation checker: RR_STARVE_CHK_EN.
`ifndef N
`define N 8
`endif

module rr_req_agent #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
`ifdef RR_STARVE_CHK_EN
    ,
    parameter int unsigned STARVE_LIMIT = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [`N-1:0]    i_in_valid,
    input  logic [`N*DW-1:0] i_in_data,
    output logic [`N-1:0]    o_in_ready,
    output logic [`N-1:0]    o_req,
    input  logic [`N-1:0]    i_grant,
    output logic             o_out_valid,
    output logic [DW-1:0]    o_out_data,
    output logic [`N-1:0]    o_out_src,
    input  logic             i_out_ready,
    output logic             o_grant_err
`ifdef RR_STARVE_CHK_EN
    ,
    output logic [`N-1:0]    o_starve_err
`endif
);
    localparam int unsigned N  = `N;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] PTR_FULL = {1'b1, {AW{1'b0}}};

    logic [AW:0]   r_wptr [N];
    logic [AW:0]   r_rptr [N];
    logic [DW-1:0] r_mem  [N][DEPTH];
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [N-1:0]  r_out_src;
    logic          r_grant_err;

    logic [N-1:0]  w_full;
    logic [N-1:0]  w_empty;
    logic [N-1:0]  w_push;
    logic [N-1:0]  w_pop;
    logic          w_slot_free;
    logic          w_grant_onehot;
    logic          w_grant_legal;
    logic          w_pop_en;
    logic [IW-1:0] w_pop_idx;
    logic [DW-1:0] w_head;

    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int i = 0; i < N; i++) begin
            w_empty[i] = (r_wptr[i] == r_rptr[i]);
            w_full[i]  = ((r_wptr[i] ^ r_rptr[i]) == PTR_FULL);
        end
    end

    assign w_slot_free = !r_out_valid || i_out_ready;
    assign o_req       = w_slot_free ? ~w_empty : '0;
    assign o_in_ready  = ~w_full;
    assign w_push      = i_in_valid & ~w_full;

    assign w_grant_onehot = (i_grant != '0) && ((i_grant & (i_grant - N'(1))) == '0);
    assign w_grant_legal  = (o_req != '0) ? (w_grant_onehot && ((i_grant & ~o_req) == '0))
                                          : (i_grant == '0);
    assign w_pop_en       = w_grant_legal && (i_grant != '0);
    assign w_pop          = w_pop_en ? i_grant : '0;

    always_comb begin
        w_pop_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_grant[i]) w_pop_idx = IW'(i);
        end
    end

    assign w_head = r_mem[w_pop_idx][r_rptr[w_pop_idx][AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < N; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_ONE;
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: emptiness is defined purely by the pointers.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N; i++) begin
            if (w_push[i]) r_mem[i][r_wptr[i][AW-1:0]] <= i_in_data[i*DW +: DW];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_grant_err <= 1'b0;
        end else begin
            if (w_pop_en) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head;
                r_out_src   <= i_grant;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (!w_grant_legal) r_grant_err <= 1'b1;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_src   = r_out_src;
    assign o_grant_err = r_grant_err;

`ifdef RR_STARVE_CHK_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SW-1:0] LIMIT   = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    logic [SW-1:0] r_starve_cnt [N];
    logic [SW-1:0] w_starve_cnt [N];
    logic [N-1:0]  r_starve_err;

    // Counts cycles a requesting port watches another port win; saturates at the limit.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_starve_cnt[i] = r_starve_cnt[i];
            if (i_grant[i]) begin
                w_starve_cnt[i] = '0;
            end else if (o_req[i] && (i_grant != '0) && (r_starve_cnt[i] != LIMIT)) begin
                w_starve_cnt[i] = r_starve_cnt[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < N; i++) r_starve_cnt[i] <= '0;
            r_starve_err <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_starve_cnt[i] <= w_starve_cnt[i];
                if (w_starve_cnt[i] == LIMIT) r_starve_err[i] <= 1'b1;
            end
        end
    end

    assign o_starve_err = r_starve_err;
`endif

endmodule

// File: tb/tb_rr_req_agent.sv
// Directed bench for rr_req_agent: vector table plus hand sequences for reset, fairness,
// grant legality and (when RR_STARVE_CHK_EN is defined) starvation flagging.
`ifndef N
`define N 8
`endif

module tb_rr_req_agent;
    localparam int unsigned N     = `N;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    out_src;
    logic            out_ready;
    logic            grant_err;
`ifdef RR_STARVE_CHK_EN
    logic [N-1:0]    starve_err;
`endif

    logic            force_mode;
    logic [N-1:0]    force_grant;
    logic [N-1:0]    arb_grant;
    int unsigned     arb_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    rr_req_agent #(.DW(DW), .DEPTH(DEPTH)) u_dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_req       (req),
        .i_grant     (grant),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_src   (out_src),
        .i_out_ready (out_ready),
        .o_grant_err (grant_err)
`ifdef RR_STARVE_CHK_EN
        ,
        .o_starve_err(starve_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference round-robin arbiter: first requester after the last winner.
    always_comb begin
        arb_grant = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (arb_grant == '0 && req[(arb_ptr + k) % N]) arb_grant[(arb_ptr + k) % N] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arb_ptr <= N - 1;
        end else if (!force_mode) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (arb_grant[k]) arb_ptr <= k;
            end
        end
    end

    assign grant = force_mode ? force_grant : arb_grant;

    typedef struct {
        logic [N-1:0]  vld;
        logic [DW-1:0] data;
        logic          ordy;
        logic [N-1:0]  exp_req;
        logic [N-1:0]  exp_rdy;
        logic          exp_ov;
        logic [DW-1:0] exp_od;
        logic [N-1:0]  exp_os;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rstn        = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        force_mode  = 1'b0;
        force_grant = '0;

        // Port 0 backpressure, full-port push while popping, then two words on port 3.
        vecs[0]  = '{8'h01, 8'hA0, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{8'h01, 8'hA1, 1'b0, 8'h01, 8'hFF, 1'b1, 8'hA0, 8'h01};
        vecs[2]  = '{8'h01, 8'hA2, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hA0, 8'h01};
        vecs[3]  = '{8'h01, 8'hA3, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hA0, 8'h01};
        vecs[4]  = '{8'h01, 8'hA4, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hA0, 8'h01};
        vecs[5]  = '{8'h01, 8'hA5, 1'b0, 8'h00, 8'hFE, 1'b1, 8'hA0, 8'h01};
        vecs[6]  = '{8'h01, 8'h5F, 1'b1, 8'h01, 8'hFE, 1'b1, 8'hA1, 8'h01};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 8'h01, 8'hFF, 1'b1, 8'hA2, 8'h01};
        vecs[8]  = '{8'h00, 8'h00, 1'b1, 8'h01, 8'hFF, 1'b1, 8'hA3, 8'h01};
        vecs[9]  = '{8'h00, 8'h00, 1'b1, 8'h01, 8'hFF, 1'b1, 8'hA4, 8'h01};
        vecs[10] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0, 8'hA4, 8'h01};
        vecs[11] = '{8'h08, 8'h11, 1'b1, 8'h00, 8'hFF, 1'b0, 8'hA4, 8'h01};
        vecs[12] = '{8'h08, 8'h22, 1'b1, 8'h08, 8'hFF, 1'b1, 8'h11, 8'h08};
        vecs[13] = '{8'h00, 8'h00, 1'b1, 8'h08, 8'hFF, 1'b1, 8'h22, 8'h08};
        vecs[14] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0, 8'h22, 8'h08};

        #1;
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_data", out_data, 8'h00);
        check("rst out_src", out_src, 8'h00);
        check("rst grant_err", grant_err, 1'b0);
        check("rst in_ready", in_ready, 8'hFF);
        check("rst req", req, 8'h00);

        do_reset();
        for (int r = 0; r < 15; r++) begin
            in_valid = vecs[r].vld;
            for (int p = 0; p < N; p++) in_data[p*DW +: DW] = vecs[r].data;
            out_ready = vecs[r].ordy;
            #3;
            check($sformatf("vec%0d req", r), req, vecs[r].exp_req);
            check($sformatf("vec%0d in_ready", r), in_ready, vecs[r].exp_rdy);
            tick();
            check($sformatf("vec%0d out_valid", r), out_valid, vecs[r].exp_ov);
            check($sformatf("vec%0d out_data", r), out_data, vecs[r].exp_od);
            check($sformatf("vec%0d out_src", r), out_src, vecs[r].exp_os);
        end
        check("vec grant_err", grant_err, 1'b0);

        // One word per port, fresh arbiter: ports served 0..N-1 back to back.
        do_reset();
        out_ready = 1'b1;
        in_valid  = '1;
        for (int p = 0; p < N; p++) in_data[p*DW +: DW] = DW'(p);
        tick();
        in_valid = '0;
        check("rr out_valid pre", out_valid, 1'b0);
        for (int k = 0; k < N; k++) begin
            tick();
            check($sformatf("rr%0d out_valid", k), out_valid, 1'b1);
            check($sformatf("rr%0d out_data", k), out_data, 64'(k));
            check($sformatf("rr%0d out_src", k), out_src, 64'(1) << k);
        end
        tick();
        check("rr out_valid drained", out_valid, 1'b0);

        // Reset asserted mid-traffic with a stalled output and a set error flag.
        do_reset();
        out_ready = 1'b0;
        in_valid  = '1;
        for (int p = 0; p < N; p++) in_data[p*DW +: DW] = 8'h5A;
        repeat (4) tick();
        in_valid = '0;
        check("midrst pre in_ready", in_ready, 8'h01);
        check("midrst pre out_valid", out_valid, 1'b1);
        force_mode  = 1'b1;
        force_grant = 8'h03;
        tick();
        check("midrst pre grant_err", grant_err, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst out_data", out_data, 8'h00);
        check("midrst out_src", out_src, 8'h00);
        check("midrst grant_err", grant_err, 1'b0);
        check("midrst in_ready", in_ready, 8'hFF);
        check("midrst req", req, 8'h00);
        force_mode  = 1'b0;
        force_grant = '0;
        @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("midrst post req", req, 8'h00);
        check("midrst post out_valid", out_valid, 1'b0);

        // Non-one-hot grant: flag, no pop; flag survives legal grants.
        force_mode  = 1'b1;
        force_grant = '0;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 8'h03;
        in_data[0*DW +: DW] = 8'hA0;
        in_data[1*DW +: DW] = 8'hB1;
        #3;
        check("gerr req empty", req, 8'h00);
        tick();
        in_valid    = '0;
        force_grant = 8'h03;
        #3;
        check("gerr req", req, 8'h03);
        tick();
        check("gerr set", grant_err, 1'b1);
        check("gerr no pop", out_valid, 1'b0);
        force_grant = 8'h01;
        tick();
        check("gerr pop0 valid", out_valid, 1'b1);
        check("gerr pop0 data", out_data, 8'hA0);
        check("gerr pop0 src", out_src, 8'h01);
        force_grant = 8'h02;
        #3;
        check("gerr req1", req, 8'h02);
        tick();
        check("gerr pop1 data", out_data, 8'hB1);
        check("gerr pop1 src", out_src, 8'h02);
        force_grant = '0;
        tick();
        check("gerr drained", out_valid, 1'b0);
        check("gerr sticky", grant_err, 1'b1);
        do_reset();
        check("gerr cleared", grant_err, 1'b0);

`ifdef RR_STARVE_CHK_EN
        // Port 0 always wins while port 1 keeps requesting.
        force_grant = '0;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 8'h03;
        tick();
        force_grant = 8'h01;
        repeat (15) tick();
        check("starve before limit", starve_err, 8'h00);
        tick();
        check("starve at limit", starve_err, 8'h02);
        check("starve grant_err", grant_err, 1'b0);
        in_valid = '0;
        force_grant = '0;
        do_reset();
        check("starve reset", starve_err, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
